// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types, response codes, slave FSM states and the byte-lane decoder
// used by the memory slave.
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'd0,
      HTRANS_BUSY   = 2'd1,
      HTRANS_NONSEQ = 2'd2,
      HTRANS_SEQ    = 2'd3
   } htrans_e;

   typedef enum logic [2:0] {
      HSIZE_BYTE  = 3'd0,
      HSIZE_HALF  = 3'd1,
      HSIZE_WORD  = 3'd2,
      HSIZE_DWORD = 3'd3
   } hsize_e;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } slave_state_e;

   // Little-endian lane enables for a bus up to 64 bits; callers keep the low DWIDTH/8 bits.
   function automatic logic [7:0] be_decode(input logic [2:0] hsize, input logic [2:0] addr_lsbs);
      logic [7:0] be;
      case (hsize)
         3'd0:    be = 8'h01 << addr_lsbs;
         3'd1:    be = 8'h03 << {addr_lsbs[2:1], 1'b0};
         3'd2:    be = 8'h0F << {addr_lsbs[2], 2'b00};
         default: be = 8'hFF;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/ahb_sram.sv
// Behavioural RAM, DEPTH x DWIDTH, with per-byte write enables and a registered read.
// Contents are deliberately not reset.
module ahb_sram #(
   parameter int DWIDTH = 32,
   parameter int DEPTH  = 1024
) (
   input  logic                       clk_i,
   input  logic [DWIDTH/8-1:0]        we_i,
   input  logic [$clog2(DEPTH)-1:0]   waddr_i,
   input  logic [DWIDTH-1:0]          wdata_i,
   input  logic                       re_i,
   input  logic [$clog2(DEPTH)-1:0]   raddr_i,
   output logic [DWIDTH-1:0]          rdata_o
);
   logic [DWIDTH-1:0] mem_q [DEPTH];
   logic [DWIDTH-1:0] rdata_q;

   // A read in the same cycle as a write to the same word returns the old contents.
   always_ff @(posedge clk_i) begin
      for (int b = 0; b < DWIDTH / 8; b++) begin
         if (we_i[b]) begin
            mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
         end
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave: address-phase capture, error screening, wait-state FSM and
// forwarding of a completing write into a read that is accepted in the same cycle.
module ahb_mem_slave
   import ahb_pkg::*;
#(
   parameter int AWIDTH      = 32,
   parameter int DWIDTH      = 32,
   parameter int DEPTH       = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic              hclk,
   input  logic              hreset_n,
   input  logic              hsel,
   input  logic [AWIDTH-1:0] haddr,
   input  logic [1:0]        htrans,
   input  logic              hwrite,
   input  logic [2:0]        hsize,
   input  logic [2:0]        hburst,
   input  logic [3:0]        hprot,
   input  logic              hmastlock,
   input  logic [DWIDTH-1:0] hwdata,
   input  logic              hready,
   output logic              hreadyout,
   output logic              hresp,
   output logic [DWIDTH-1:0] hrdata
);
   localparam int NBYTES = DWIDTH / 8;
   localparam int LSB_W  = $clog2(NBYTES);
   localparam int IDX_W  = $clog2(DEPTH);
   localparam int BYTES  = DEPTH * NBYTES;

   slave_state_e      state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              wr_q;
   logic [NBYTES-1:0] be_q, fwd_be_q, acc_be, ram_we;
   logic [IDX_W-1:0]  idx_q, acc_idx;
   logic [DWIDTH-1:0] fwd_data_q, ram_rdata, merged;
   logic              slot_free, take, acc_err, wr_commit, ram_re, rd_valid;
   logic [2:0]        lsb3;
   logic              unused_ok;

   assign unused_ok = ^{hburst, hprot, hmastlock};

   assign slot_free = (state_q != ST_WAIT) && (state_q != ST_ERR1);
   assign take      = hsel & hready & htrans[1] & slot_free;
   assign lsb3      = 3'(haddr[LSB_W-1:0]);
   assign acc_idx   = haddr[LSB_W +: IDX_W];
   assign acc_be    = NBYTES'(be_decode(hsize, lsb3));
   // Range check uses the full address so high bits never alias into the array.
   assign acc_err   = (haddr >= AWIDTH'(BYTES))
                   || (hsize > 3'(LSB_W))
                   || ((lsb3 & ((3'd1 << hsize) - 3'd1)) != 3'd0);

   assign wr_commit = (state_q == ST_DATA) && wr_q;
   assign ram_we    = wr_commit ? be_q : '0;
   assign ram_re    = take && !hwrite && !acc_err;
   assign rd_valid  = (state_q == ST_DATA) && !wr_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hreadyout = 1'b1;
      hresp     = HRESP_OKAY;
      case (state_q)
         ST_WAIT: begin
            hreadyout = 1'b0;
            if (cnt_q == 4'(WAIT_STATES)) begin
               state_d = ST_DATA;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_ERR1: begin
            hreadyout = 1'b0;
            hresp     = HRESP_ERROR;
            state_d   = ST_ERR2;
         end
         default: begin
            // IDLE, DATA and ERR2 all end with hreadyout high, so a new address phase may start.
            if (state_q == ST_ERR2) begin
               hresp = HRESP_ERROR;
            end
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
            if (take) begin
               if (acc_err) begin
                  state_d = ST_ERR1;
               end else if (WAIT_STATES > 0) begin
                  state_d = ST_WAIT;
                  cnt_d   = 4'd1;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
      endcase
   end

   always_ff @(posedge hclk) begin
      if (!hreset_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 4'd0;
         wr_q       <= 1'b0;
         be_q       <= '0;
         idx_q      <= '0;
         fwd_be_q   <= '0;
         fwd_data_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (take) begin
            wr_q       <= hwrite & ~acc_err;
            be_q       <= acc_be;
            idx_q      <= acc_idx;
            fwd_be_q   <= (wr_commit && (idx_q == acc_idx)) ? be_q : '0;
            fwd_data_q <= hwdata;
         end
      end
   end

   ahb_sram #(
      .DWIDTH (DWIDTH),
      .DEPTH  (DEPTH)
   ) u_sram (
      .clk_i   (hclk),
      .we_i    (ram_we),
      .waddr_i (idx_q),
      .wdata_i (hwdata),
      .re_i    (ram_re),
      .raddr_i (acc_idx),
      .rdata_o (ram_rdata)
   );

   genvar gi;
   generate
      for (gi = 0; gi < NBYTES; gi++) begin : g_lane
         assign merged[gi*8 +: 8] = fwd_be_q[gi] ? fwd_data_q[gi*8 +: 8] : ram_rdata[gi*8 +: 8];
         assign hrdata[gi*8 +: 8] = (rd_valid && be_q[gi]) ? merged[gi*8 +: 8] : 8'h00;
      end
   endgenerate

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Bench for ahb_mem_slave: directed tables and a hand-written reset sequence on a zero-wait
// and a three-wait instance, then random traffic checked against a byte-array memory model.
module tb_ahb_mem_slave;
   localparam int BYTES = 4096;
   localparam int WS0   = 0;
   localparam int WS1   = 3;
   localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NS = 2'd2, T_SEQ = 2'd3;
   localparam logic [2:0] S_B = 3'd0, S_H = 3'd1, S_W = 3'd2, S_D = 3'd3;

   typedef struct {
      logic        sel;
      logic [1:0]  trans;
      logic        wr;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } xfer_t;

   logic        hclk = 1'b0;
   logic        hreset_n  [2];
   logic        hsel      [2];
   logic [31:0] haddr     [2];
   logic [1:0]  htrans    [2];
   logic        hwrite    [2];
   logic [2:0]  hsize     [2];
   logic [31:0] hwdata    [2];
   logic        hreadyout [2];
   logic        hresp     [2];
   logic [31:0] hrdata    [2];

   int          total = 0;
   int          bad   = 0;
   xfer_t       xf [$];
   logic [7:0]  ref_mem [2][64];
   xfer_t       tab0 [20];
   xfer_t       tab1 [7];

   always #5 hclk = ~hclk;

   ahb_mem_slave #(.AWIDTH(32), .DWIDTH(32), .DEPTH(1024), .WAIT_STATES(WS0)) u_ws0 (
      .hclk(hclk), .hreset_n(hreset_n[0]), .hsel(hsel[0]), .haddr(haddr[0]),
      .htrans(htrans[0]), .hwrite(hwrite[0]), .hsize(hsize[0]), .hburst(3'b001),
      .hprot(4'b0011), .hmastlock(1'b0), .hwdata(hwdata[0]), .hready(hreadyout[0]),
      .hreadyout(hreadyout[0]), .hresp(hresp[0]), .hrdata(hrdata[0])
   );

   ahb_mem_slave #(.AWIDTH(32), .DWIDTH(32), .DEPTH(1024), .WAIT_STATES(WS1)) u_ws3 (
      .hclk(hclk), .hreset_n(hreset_n[1]), .hsel(hsel[1]), .haddr(haddr[1]),
      .htrans(htrans[1]), .hwrite(hwrite[1]), .hsize(hsize[1]), .hburst(3'b000),
      .hprot(4'b0001), .hmastlock(1'b0), .hwdata(hwdata[1]), .hready(hreadyout[1]),
      .hreadyout(hreadyout[1]), .hresp(hresp[1]), .hrdata(hrdata[1])
   );

   function automatic int ws_of(input int d);
      return (d == 0) ? WS0 : WS1;
   endfunction

   function automatic xfer_t mk(input logic sel, input logic [1:0] tr, input logic wr,
                                input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                                input logic e, input logic [31:0] rd);
      xfer_t x;
      x.sel = sel; x.trans = tr; x.wr = wr; x.size = sz; x.addr = a; x.wdata = wd;
      x.exp_err = e; x.exp_rdata = rd;
      return x;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic idle(input int d);
      hsel[d] = 1'b0; htrans[d] = T_IDLE; hwrite[d] = 1'b0; hsize[d] = S_W; haddr[d] = '0;
   endtask

   // Reference behaviour: transfers complete in order against a flat byte array.
   task automatic model_push(input int d, input logic wr, input logic [2:0] sz,
                             input logic [31:0] a, input logic [31:0] wd);
      logic        err;
      logic [31:0] rd;
      int          lane;
      err = (a >= 32'(BYTES)) || (sz > 3'd2) || ((a % (32'd1 << sz)) != 32'd0);
      rd  = '0;
      if (!err) begin
         for (int i = 0; i < (1 << sz); i++) begin
            lane = int'(a % 4) + i;
            if (wr) ref_mem[d][a + i] = wd[lane*8 +: 8];
            else    rd[lane*8 +: 8]   = ref_mem[d][a + i];
         end
      end
      xf.push_back(mk(1'b1, T_NS, wr, sz, a, wd, err, wr ? 32'd0 : rd));
   endtask

   // Drives the queued transfers pipelined (hready = hreadyout) and checks every data-phase cycle.
   task automatic run_list(input int d);
      int          n, ai, di, k;
      logic        rdy, rsp, last;
      logic [31:0] rd, exp_rd;
      n = xf.size(); ai = 0; di = -1; k = 0;
      while (ai < n || di >= 0) begin
         if (ai < n) begin
            hsel[d] = xf[ai].sel; htrans[d] = xf[ai].trans; hwrite[d] = xf[ai].wr;
            hsize[d] = xf[ai].size; haddr[d] = xf[ai].addr;
         end else begin
            idle(d);
         end
         hwdata[d] = (di >= 0) ? (xf[di].wr ? xf[di].wdata : $urandom()) : $urandom();
         @(negedge hclk);
         rdy = hreadyout[d]; rsp = hresp[d]; rd = hrdata[d];
         if (di < 0) begin
            check($sformatf("d%0d_nophase_ctl", d), {30'd0, rdy, rsp}, 32'd2);
            check($sformatf("d%0d_nophase_rdata", d), rd, 32'd0);
            rdy = 1'b1;
         end else begin
            last   = xf[di].exp_err ? (k == 1) : (k == ws_of(d));
            exp_rd = (last && !xf[di].exp_err) ? xf[di].exp_rdata : 32'd0;
            check($sformatf("d%0d_x%0d_c%0d_ctl", d, di, k), {30'd0, rdy, rsp},
                  {30'd0, last, xf[di].exp_err});
            check($sformatf("d%0d_x%0d_c%0d_rdata", d, di, k), rd, exp_rd);
            if (rdy) begin
               $display("dut%0d xfer %0d: addr=%h wr=%0d size=%0d resp=%0d rdata=%h",
                        d, di, xf[di].addr, xf[di].wr, xf[di].size, rsp, rd);
            end
            k++;
            if (!rdy && k > ws_of(d) + 4) begin
               total++; bad++;
               $display("FAIL d%0d_x%0d_stall: got=hreadyout stuck low want=complete", d, di);
               rdy = 1'b1;
            end
         end
         if (rdy) begin
            k = 0;
            if (ai < n) begin
               di = (xf[ai].sel && xf[ai].trans[1]) ? ai : -1;
               ai++;
            end else begin
               di = -1;
            end
         end
         @(posedge hclk); #1;
      end
      idle(d);
      xf.delete();
   endtask

   task automatic gen_random(input int d, input int n);
      int          r;
      logic [2:0]  sz;
      logic [31:0] a;
      for (int w = 0; w < 16; w++) model_push(d, 1'b1, S_W, 32'(w * 4), $urandom());
      for (int i = 0; i < n; i++) begin
         r  = $urandom_range(0, 19);
         sz = 3'($urandom_range(0, 3));
         a  = 32'($urandom_range(0, 63));
         if (r < 2) begin
            xf.push_back(mk(r == 1, (r == 0) ? T_NS : 2'($urandom_range(0, 1)),
                            1'($urandom_range(0, 1)), sz, a, $urandom(), 1'b0, 32'd0));
         end else begin
            if (r == 2)                   a = 32'(BYTES) + a;
            else if (r == 3)              a = {1'b1, a[30:0]};
            else if (r < 17 && sz <= S_W) a = a & ~((32'd1 << sz) - 32'd1);
            model_push(d, 1'($urandom_range(0, 1)), sz, a, $urandom());
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tab0[0]  = mk(1, T_NS,   1, S_W, 32'h10,   32'hDEADBEEF, 0, 32'h0);
      tab0[1]  = mk(1, T_NS,   0, S_W, 32'h10,   32'h0,        0, 32'hDEADBEEF);
      tab0[2]  = mk(1, T_SEQ,  1, S_W, 32'h10,   32'h11223344, 0, 32'h0);
      tab0[3]  = mk(1, T_NS,   1, S_B, 32'h13,   32'hAA000000, 0, 32'h0);
      tab0[4]  = mk(1, T_NS,   0, S_W, 32'h10,   32'h0,        0, 32'hAA223344);
      tab0[5]  = mk(1, T_NS,   0, S_H, 32'h12,   32'h0,        0, 32'hAA220000);
      tab0[6]  = mk(1, T_NS,   0, S_B, 32'h11,   32'h0,        0, 32'h00003300);
      tab0[7]  = mk(1, T_NS,   0, S_W, 32'h1000, 32'h0,        1, 32'h0);
      tab0[8]  = mk(1, T_NS,   0, S_H, 32'h1,    32'h0,        1, 32'h0);
      tab0[9]  = mk(1, T_NS,   1, S_W, 32'h12,   32'hFFFFFFFF, 1, 32'h0);
      tab0[10] = mk(1, T_NS,   0, S_W, 32'h10,   32'h0,        0, 32'hAA223344);
      tab0[11] = mk(1, T_IDLE, 1, S_W, 32'h10,   32'h0,        0, 32'h0);
      tab0[12] = mk(1, T_BUSY, 1, S_W, 32'h10,   32'h0,        0, 32'h0);
      tab0[13] = mk(0, T_NS,   1, S_W, 32'h10,   32'h0,        0, 32'h0);
      tab0[14] = mk(1, T_NS,   0, S_D, 32'h10,   32'h0,        1, 32'h0);
      tab0[15] = mk(1, T_NS,   1, S_W, 32'h80000010, 32'h0,    1, 32'h0);
      tab0[16] = mk(1, T_NS,   0, S_W, 32'h10,   32'h0,        0, 32'hAA223344);
      tab0[17] = mk(1, T_NS,   1, S_W, 32'hFFC,  32'hCAFEF00D, 0, 32'h0);
      tab0[18] = mk(1, T_NS,   0, S_B, 32'hFFF,  32'h0,        0, 32'hCA000000);
      tab0[19] = mk(1, T_NS,   0, S_B, 32'h1000, 32'h0,        1, 32'h0);

      tab1[0]  = mk(1, T_NS,   1, S_W, 32'h20,   32'h5A5AA5A5, 0, 32'h0);
      tab1[1]  = mk(1, T_NS,   0, S_W, 32'h20,   32'h0,        0, 32'h5A5AA5A5);
      tab1[2]  = mk(1, T_NS,   1, S_H, 32'h22,   32'hBEEF0000, 0, 32'h0);
      tab1[3]  = mk(1, T_NS,   0, S_W, 32'h20,   32'h0,        0, 32'hBEEFA5A5);
      tab1[4]  = mk(1, T_NS,   0, S_W, 32'h1000, 32'h0,        1, 32'h0);
      tab1[5]  = mk(1, T_NS,   0, S_H, 32'h21,   32'h0,        1, 32'h0);
      tab1[6]  = mk(1, T_NS,   0, S_H, 32'h20,   32'h0,        0, 32'h0000A5A5);

      for (int d = 0; d < 2; d++) begin
         hreset_n[d] = 1'b0; idle(d); hwdata[d] = '0;
      end
      repeat (3) @(posedge hclk);
      @(negedge hclk);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("d%0d_reset_ctl", d), {30'd0, hreadyout[d], hresp[d]}, 32'd2);
         check($sformatf("d%0d_reset_rdata", d), hrdata[d], 32'd0);
      end
      @(posedge hclk); #1;
      hreset_n[0] = 1'b1; hreset_n[1] = 1'b1;
      @(posedge hclk); #1;

      for (int i = 0; i < 20; i++) xf.push_back(tab0[i]);
      run_list(0);
      for (int i = 0; i < 7; i++) xf.push_back(tab1[i]);
      run_list(1);

      // Reset in the middle of a waited write must abort it without touching the RAM.
      xf.push_back(mk(1, T_NS, 1, S_W, 32'h30, 32'h0A0B0C0D, 0, 32'h0));
      run_list(1);
      hsel[1] = 1'b1; htrans[1] = T_NS; hwrite[1] = 1'b1; hsize[1] = S_W; haddr[1] = 32'h30;
      @(posedge hclk); #1;
      idle(1); hwdata[1] = 32'hFFFFFFFF;
      @(negedge hclk);
      check("rst_in_wait_ctl", {30'd0, hreadyout[1], hresp[1]}, 32'd0);
      @(posedge hclk); #1;
      hreset_n[1] = 1'b0;
      @(posedge hclk); #1;
      @(negedge hclk);
      check("rst_mid_ctl", {30'd0, hreadyout[1], hresp[1]}, 32'd2);
      check("rst_mid_rdata", hrdata[1], 32'd0);
      @(posedge hclk); #1;
      hreset_n[1] = 1'b1;
      @(negedge hclk);
      check("rst_after_ctl", {30'd0, hreadyout[1], hresp[1]}, 32'd2);
      @(posedge hclk); #1;
      xf.push_back(mk(1, T_NS, 0, S_W, 32'h30, 32'h0, 0, 32'h0A0B0C0D));
      run_list(1);

      for (int d = 0; d < 2; d++) begin
         gen_random(d, 150);
         run_list(d);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
